// File: rtl/scalar_wb_arbiter.sv
// Writeback arbiter in front of the scalar register file write port.
// Load results always win; ALU results that lose arbitration wait in a small in-order FIFO.
module scalar_wb_arbiter #(
   parameter int DATA_W     = 16,
   parameter int ADDR_W     = 4,
   parameter int FIFO_DEPTH = 2
) (
   input  logic                                 clk,
   input  logic                                 rst,
   input  logic                                 alu_valid,
   output logic                                 alu_ready,
   input  logic [ADDR_W-1:0]                    alu_dst,
   input  logic [DATA_W-1:0]                    alu_data,
   input  logic                                 mem_valid,
   input  logic [ADDR_W-1:0]                    mem_dst,
   input  logic [DATA_W-1:0]                    mem_data,
   output logic                                 wr_en,
   output logic [ADDR_W-1:0]                    wr_dst,
   output logic [DATA_W-1:0]                    wr_data,
   output logic [(2**ADDR_W)-1:0]               busy_mask,
   output logic [$clog2(FIFO_DEPTH+1)-1:0]      fifo_count,
   output logic [7:0]                           stall_cnt
);

   localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
   localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

   typedef enum logic [1:0] {
      SRC_NONE,
      SRC_MEM,
      SRC_FIFO,
      SRC_ALU
   } src_t;

   logic [DATA_W-1:0]     q_data [FIFO_DEPTH];
   logic [ADDR_W-1:0]     q_dst  [FIFO_DEPTH];
   logic [FIFO_DEPTH-1:0] q_vld;
   logic [PTR_W-1:0]      head;
   logic [PTR_W-1:0]      tail;
   logic [CNT_W-1:0]      count;

   src_t src;
   logic accept;
   logic push;
   logic pop;

   function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
      if (p == PTR_W'(FIFO_DEPTH - 1))
         return '0;
      else
         return p + PTR_W'(1);
   endfunction

   // Refusal only happens when the queue is full and a load steals the write port.
   assign alu_ready  = !rst && ((count < CNT_W'(FIFO_DEPTH)) || !mem_valid);
   assign accept     = alu_valid && alu_ready;
   assign fifo_count = count;

   always_comb begin
      src  = SRC_NONE;
      push = 1'b0;
      pop  = 1'b0;
      if (mem_valid) begin
         src  = SRC_MEM;
         push = accept;
      end else if (count != '0) begin
         src  = SRC_FIFO;
         pop  = 1'b1;
         push = accept;
      end else if (alu_valid) begin
         src  = SRC_ALU;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         head  <= '0;
         tail  <= '0;
         count <= '0;
         q_vld <= '0;
      end else begin
         if (pop) begin
            head        <= next_ptr(head);
            q_vld[head] <= 1'b0;
         end
         // Issued after the pop clear so a full-queue push into the slot being drained wins.
         if (push) begin
            tail        <= next_ptr(tail);
            q_vld[tail] <= 1'b1;
         end
         case ({push, pop})
            2'b10:   count <= count + CNT_W'(1);
            2'b01:   count <= count - CNT_W'(1);
            default: count <= count;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (!rst && push) begin
         q_dst[tail]  <= alu_dst;
         q_data[tail] <= alu_data;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_en   <= 1'b0;
         wr_dst  <= '0;
         wr_data <= '0;
      end else begin
         case (src)
            SRC_MEM: begin
               wr_en   <= 1'b1;
               wr_dst  <= mem_dst;
               wr_data <= mem_data;
            end
            SRC_FIFO: begin
               wr_en   <= 1'b1;
               wr_dst  <= q_dst[head];
               wr_data <= q_data[head];
            end
            SRC_ALU: begin
               wr_en   <= 1'b1;
               wr_dst  <= alu_dst;
               wr_data <= alu_data;
            end
            default: wr_en <= 1'b0;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst)
         stall_cnt <= '0;
      else if (alu_valid && !alu_ready && (stall_cnt != 8'hFF))
         stall_cnt <= stall_cnt + 8'd1;
   end

   always_comb begin
      busy_mask = '0;
      for (int unsigned i = 0; i < FIFO_DEPTH; i++) begin
         if (q_vld[i])
            busy_mask[q_dst[i]] = 1'b1;
      end
      if (wr_en)
         busy_mask[wr_dst] = 1'b1;
   end

endmodule

// File: tb/tb_scalar_wb_arbiter.sv
// Directed bench for scalar_wb_arbiter with hand-computed expectations
// (DATA_W=16, ADDR_W=4, FIFO_DEPTH=2).
module tb_scalar_wb_arbiter;

   logic        clk = 1'b0;
   logic        rst;
   logic        alu_valid;
   logic        alu_ready;
   logic [3:0]  alu_dst;
   logic [15:0] alu_data;
   logic        mem_valid;
   logic [3:0]  mem_dst;
   logic [15:0] mem_data;
   logic        wr_en;
   logic [3:0]  wr_dst;
   logic [15:0] wr_data;
   logic [15:0] busy_mask;
   logic [1:0]  fifo_count;
   logic [7:0]  stall_cnt;

   int checks   = 0;
   int failures = 0;

   always #5 clk = ~clk;

   scalar_wb_arbiter #(
      .DATA_W     (16),
      .ADDR_W     (4),
      .FIFO_DEPTH (2)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .alu_valid  (alu_valid),
      .alu_ready  (alu_ready),
      .alu_dst    (alu_dst),
      .alu_data   (alu_data),
      .mem_valid  (mem_valid),
      .mem_dst    (mem_dst),
      .mem_data   (mem_data),
      .wr_en      (wr_en),
      .wr_dst     (wr_dst),
      .wr_data    (wr_data),
      .busy_mask  (busy_mask),
      .fifo_count (fifo_count),
      .stall_cnt  (stall_cnt)
   );

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   task automatic drive(input logic mv, input logic [3:0] md, input logic [15:0] mdat,
                        input logic av, input logic [3:0] ad, input logic [15:0] adat);
      mem_valid = mv;
      mem_dst   = md;
      mem_data  = mdat;
      alu_valid = av;
      alu_dst   = ad;
      alu_data  = adat;
      #1;
   endtask

   task automatic chk_wr(input string tag, input logic en, input logic [3:0] d, input logic [15:0] v);
      chk({tag, "_wr_en"}, 32'(wr_en), 32'(en));
      chk({tag, "_wr_dst"}, 32'(wr_dst), 32'(d));
      chk({tag, "_wr_data"}, 32'(wr_data), 32'(v));
   endtask

   initial begin
      rst = 1'b1;
      drive(1'b0, 4'd0, 16'h0, 1'b0, 4'd0, 16'h0);

      // reset state
      step();
      step();
      chk_wr("rst", 1'b0, 4'd0, 16'h0000);
      chk("rst_count", 32'(fifo_count), 32'd0);
      chk("rst_stall", 32'(stall_cnt), 32'd0);
      chk("rst_busy", 32'(busy_mask), 32'h0);
      drive(1'b0, 4'd0, 16'h0, 1'b1, 4'd3, 16'h1234);
      chk("rst_ready_low", 32'(alu_ready), 32'd0);
      rst = 1'b0;
      #1;
      chk("post_rst_ready", 32'(alu_ready), 32'd1);

      // ALU only: bypass straight to the write port
      step();
      drive(1'b0, 4'd0, 16'h0, 1'b0, 4'd0, 16'h0);
      chk_wr("alu_only", 1'b1, 4'd3, 16'h1234);
      chk("alu_only_count", 32'(fifo_count), 32'd0);
      chk("alu_only_busy", 32'(busy_mask), 32'h0008);
      step();
      chk_wr("alu_idle_hold", 1'b0, 4'd3, 16'h1234);
      chk("alu_idle_busy", 32'(busy_mask), 32'h0);

      // collision: load wins, ALU queued
      drive(1'b1, 4'd5, 16'hAAAA, 1'b1, 4'd6, 16'h5555);
      chk("col_ready", 32'(alu_ready), 32'd1);
      step();
      drive(1'b0, 4'd0, 16'h0, 1'b0, 4'd0, 16'h0);
      chk_wr("col_n1", 1'b1, 4'd5, 16'hAAAA);
      chk("col_n1_count", 32'(fifo_count), 32'd1);
      chk("col_n1_busy", 32'(busy_mask), 32'h0060);
      step();
      chk_wr("col_n2", 1'b1, 4'd6, 16'h5555);
      chk("col_n2_count", 32'(fifo_count), 32'd0);
      chk("col_n2_busy", 32'(busy_mask), 32'h0040);
      step();
      chk("col_n3_wr_en", 32'(wr_en), 32'd0);
      chk("col_n3_busy", 32'(busy_mask), 32'h0);

      // back-pressure: four load cycles, ALU offers every cycle
      drive(1'b1, 4'd10, 16'h0A0A, 1'b1, 4'd1, 16'h0101);
      chk("bp1_ready", 32'(alu_ready), 32'd1);
      step();
      chk_wr("bp1", 1'b1, 4'd10, 16'h0A0A);
      chk("bp1_count", 32'(fifo_count), 32'd1);
      drive(1'b1, 4'd11, 16'h0B0B, 1'b1, 4'd2, 16'h0202);
      chk("bp2_ready", 32'(alu_ready), 32'd1);
      step();
      chk_wr("bp2", 1'b1, 4'd11, 16'h0B0B);
      chk("bp2_count", 32'(fifo_count), 32'd2);
      drive(1'b1, 4'd12, 16'h0C0C, 1'b1, 4'd3, 16'h0303);
      chk("bp3_ready", 32'(alu_ready), 32'd0);
      step();
      chk("bp3_stall", 32'(stall_cnt), 32'd1);
      drive(1'b1, 4'd13, 16'h0D0D, 1'b1, 4'd3, 16'h0303);
      chk("bp4_ready", 32'(alu_ready), 32'd0);
      step();
      chk_wr("bp4", 1'b1, 4'd13, 16'h0D0D);
      chk("bp4_count", 32'(fifo_count), 32'd2);
      chk("bp4_stall", 32'(stall_cnt), 32'd2);
      chk("bp4_busy", 32'(busy_mask), 32'h2006);
      drive(1'b0, 4'd0, 16'h0, 1'b1, 4'd3, 16'h0303);
      chk("bp5_ready", 32'(alu_ready), 32'd1);
      step();
      drive(1'b0, 4'd0, 16'h0, 1'b0, 4'd0, 16'h0);
      chk_wr("bp5", 1'b1, 4'd1, 16'h0101);
      chk("bp5_count", 32'(fifo_count), 32'd2);
      chk("bp5_stall", 32'(stall_cnt), 32'd2);
      step();
      chk_wr("bp6", 1'b1, 4'd2, 16'h0202);
      chk("bp6_count", 32'(fifo_count), 32'd1);
      step();
      chk_wr("bp7", 1'b1, 4'd3, 16'h0303);
      chk("bp7_count", 32'(fifo_count), 32'd0);
      step();
      chk("bp8_wr_en", 32'(wr_en), 32'd0);

      // full queue, no load: drain and refill in the same cycle
      drive(1'b1, 4'd7, 16'h7777, 1'b1, 4'd8, 16'h0808);
      step();
      drive(1'b1, 4'd7, 16'h7778, 1'b1, 4'd4, 16'h0404);
      step();
      chk("full_count", 32'(fifo_count), 32'd2);
      drive(1'b0, 4'd0, 16'h0, 1'b1, 4'd9, 16'h0909);
      chk("full_ready", 32'(alu_ready), 32'd1);
      step();
      drive(1'b0, 4'd0, 16'h0, 1'b0, 4'd0, 16'h0);
      chk_wr("full_head", 1'b1, 4'd8, 16'h0808);
      chk("full_count_hold", 32'(fifo_count), 32'd2);
      chk("full_busy", 32'(busy_mask), 32'h0310);
      step();
      chk_wr("full_next", 1'b1, 4'd4, 16'h0404);
      step();
      chk_wr("full_last", 1'b1, 4'd9, 16'h0909);
      chk("full_drained", 32'(fifo_count), 32'd0);
      step();

      // reset mid-operation discards queued writes and clears stall_cnt
      drive(1'b1, 4'd2, 16'h2222, 1'b1, 4'd5, 16'h5050);
      step();
      drive(1'b1, 4'd3, 16'h3333, 1'b1, 4'd6, 16'h6060);
      step();
      chk("mid_count", 32'(fifo_count), 32'd2);
      chk("mid_wr_en", 32'(wr_en), 32'd1);
      rst = 1'b1;
      #1;
      chk("mid_rst_ready", 32'(alu_ready), 32'd0);
      step();
      rst = 1'b0;
      drive(1'b0, 4'd0, 16'h0, 1'b0, 4'd0, 16'h0);
      chk_wr("mid_rst", 1'b0, 4'd0, 16'h0000);
      chk("mid_rst_count", 32'(fifo_count), 32'd0);
      chk("mid_rst_busy", 32'(busy_mask), 32'h0);
      chk("mid_rst_stall", 32'(stall_cnt), 32'd0);
      step();
      chk("mid_rst_no_drain", 32'(wr_en), 32'd0);

      // saturation: full queue held under continuous loads
      drive(1'b1, 4'd0, 16'h0000, 1'b1, 4'd14, 16'hE0E0);
      step();
      drive(1'b1, 4'd0, 16'h0000, 1'b1, 4'd15, 16'hF0F0);
      step();
      drive(1'b1, 4'd0, 16'h0000, 1'b1, 4'd12, 16'hC0C0);
      for (int i = 0; i < 10; i++) step();
      chk("sat_stall10", 32'(stall_cnt), 32'd10);
      for (int i = 0; i < 290; i++) step();
      chk("sat_stall255", 32'(stall_cnt), 32'd255);
      chk("sat_count", 32'(fifo_count), 32'd2);
      drive(1'b0, 4'd0, 16'h0, 1'b1, 4'd12, 16'hC0C0);
      step();
      drive(1'b0, 4'd0, 16'h0, 1'b0, 4'd0, 16'h0);
      chk_wr("sat_drain1", 1'b1, 4'd14, 16'hE0E0);
      step();
      chk_wr("sat_drain2", 1'b1, 4'd15, 16'hF0F0);
      step();
      chk_wr("sat_drain3", 1'b1, 4'd12, 16'hC0C0);
      chk("sat_final_count", 32'(fifo_count), 32'd0);
      chk("sat_stall_hold", 32'(stall_cnt), 32'd255);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
